// File: rtl/tdm_pkg.sv
// Shared definitions for the 4:1 TDM link (framer and demultiplexer sides).
package tdm_pkg;

  localparam int unsigned TDM_NCH  = 4;
  localparam int unsigned TDM_SELW = 2;

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } tdm_state_e;

  typedef logic [TDM_SELW-1:0] tdm_slot_t;

  // One-hot channel mask for a slot index.
  function automatic logic [TDM_NCH-1:0] slot_onehot(input tdm_slot_t s);
    logic [TDM_NCH-1:0] r;
    r    = '0;
    r[s] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// Link-side beat inputs and frame-side outputs of the TDM demultiplexer.
interface tdm_demux4_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4
);

  logic                 in_valid;
  logic                 in_sync;
  logic [WIDTH-1:0]     in_data;
  logic [NCH*WIDTH-1:0] out_frame;
  logic                 out_valid;
  logic [NCH-1:0]       ch_stb;
  logic                 locked;
  logic                 sync_err;

  // Upstream front-end / bench side.
  modport master (
    output in_valid, in_sync, in_data,
    input  out_frame, out_valid, ch_stb, locked, sync_err
  );

  // Demultiplexer side.
  modport slave (
    input  in_valid, in_sync, in_data,
    output out_frame, out_valid, ch_stb, locked, sync_err
  );

endinterface

// File: rtl/tdm_slot_counter.sv
// Slot index counter, wraps modulo TDM_NCH. clr and inc together load 1, which
// is how an accepted slot-0 beat advances straight to the next slot.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      inc,
  input  logic      clr,
  output tdm_slot_t slot,
  output logic      last
);

  tdm_slot_t slot_q, slot_d;

  // Next slot: optional clear, then optional increment (natural 2-bit wrap).
  always_comb begin
    slot_d = clr ? '0 : slot_q;
    if (inc) begin
      slot_d = slot_d + tdm_slot_t'(1);
    end
  end

  // Slot register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;
  assign last = (slot_q == tdm_slot_t'(TDM_NCH - 1));

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: aligns on the frame-sync marker, collects
// slots 0..2 in shadow registers and publishes whole frames on the slot-3 beat.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = TDM_NCH  // fixed at 4
) (
  input logic         clk,
  input logic         rst,
  tdm_demux4_if.slave bus
);

  tdm_state_e state_q, state_d;

  tdm_slot_t slot;
  logic      last;
  logic      inc;
  logic      clr;

  logic       sh_we;
  tdm_slot_t  sh_idx;
  logic [WIDTH-1:0] sh_q [NCH-1];

  logic [NCH*WIDTH-1:0] frame_q, frame_d;
  logic                 ov_q, ov_d;
  logic [NCH-1:0]       stb_q, stb_d;
  logic                 err_q, err_d;

  tdm_slot_counter u_slot_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (inc),
    .clr  (clr),
    .slot (slot),
    .last (last)
  );

  // Framing FSM: next state, counter control, shadow write and output pulses.
  always_comb begin
    state_d = state_q;
    inc     = 1'b0;
    clr     = 1'b0;
    sh_we   = 1'b0;
    sh_idx  = '0;
    ov_d    = 1'b0;
    err_d   = 1'b0;
    stb_d   = '0;
    frame_d = frame_q;

    if (bus.in_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          // Non-sync beats are dropped silently while hunting.
          if (bus.in_sync) begin
            state_d = ST_LOCKED;
            clr     = 1'b1;
            inc     = 1'b1;
            sh_we   = 1'b1;
            stb_d   = slot_onehot('0);
          end
        end
        ST_LOCKED: begin
          if (slot == '0) begin
            if (bus.in_sync) begin
              inc   = 1'b1;
              sh_we = 1'b1;
              stb_d = slot_onehot('0);
            end else begin
              // Missing sync: lose alignment, drop the beat.
              err_d   = 1'b1;
              clr     = 1'b1;
              state_d = ST_HUNT;
            end
          end else if (bus.in_sync) begin
            // Early sync: abandon the partial frame and restart at slot 0.
            err_d = 1'b1;
            clr   = 1'b1;
            inc   = 1'b1;
            sh_we = 1'b1;
            stb_d = slot_onehot('0);
          end else begin
            inc   = 1'b1;
            stb_d = slot_onehot(slot);
            if (last) begin
              ov_d = 1'b1;
              for (int k = 0; k < int'(NCH) - 1; k++) begin
                frame_d[k*WIDTH +: WIDTH] = sh_q[k];
              end
              frame_d[(NCH-1)*WIDTH +: WIDTH] = bus.in_data;
            end else begin
              sh_we  = 1'b1;
              sh_idx = slot;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HUNT;
      frame_q <= '0;
      ov_q    <= 1'b0;
      stb_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      ov_q    <= ov_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
    end
  end

  // Shadow registers for slots 0..NCH-2; the last slot goes straight to the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(NCH) - 1; k++) begin
        sh_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(NCH) - 1; k++) begin
        if (sh_we && (sh_idx == tdm_slot_t'(k))) begin
          sh_q[k] <= bus.in_data;
        end
      end
    end
  end

  assign bus.out_frame = frame_q;
  assign bus.out_valid = ov_q;
  assign bus.ch_stb    = stb_q;
  assign bus.sync_err  = err_q;
  assign bus.locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 with a queue-based scoreboard and pulse monitor.
module tb_tdm_demux4;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NCH   = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tdm_demux4_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

  tdm_demux4 #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0]  stb;
    logic        err;
    logic        ov;
    logic [31:0] frame;
    logic        lk;
  } ev_t;

  ev_t exq[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  ov_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle with a pulse on an output is matched to the next expected event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst !== 1'b1 && (bus.out_valid || bus.ch_stb != '0 || bus.sync_err)) begin
        if (bus.out_valid) ov_cyc.push_back(cyc);
        if (exq.size() == 0) begin
          chk("unexpected_pulse", 32'({bus.ch_stb, bus.sync_err, bus.out_valid}), 32'h0);
        end else begin
          e = exq.pop_front();
          chk("ch_stb", 32'(bus.ch_stb), 32'(e.stb));
          chk("sync_err", 32'(bus.sync_err), 32'(e.err));
          chk("out_valid", 32'(bus.out_valid), 32'(e.ov));
          chk("locked", 32'(bus.locked), 32'(e.lk));
          if (e.ov) chk("out_frame", bus.out_frame, e.frame);
        end
      end
    end
  end

  // Issue one beat; expected pulses (if any) are queued before the sampling edge.
  task automatic beat(input logic v, input logic s, input logic [7:0] d,
                      input logic [3:0] stb = 4'h0, input logic err = 1'b0,
                      input logic ov = 1'b0, input logic [31:0] fr = 32'h0,
                      input logic lk = 1'b1);
    ev_t e;
    if (stb != 4'h0 || err || ov) begin
      e = '{stb: stb, err: err, ov: ov, frame: fr, lk: lk};
      exq.push_back(e);
    end
    bus.in_valid = v;
    bus.in_sync  = s;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_frame"}, bus.out_frame, 32'h0);
    chk({tag, "_pulses"}, 32'({bus.ch_stb, bus.sync_err, bus.out_valid}), 32'h0);
    chk({tag, "_locked"}, 32'(bus.locked), 32'h0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    bus.in_data  = '0;
    rst = 1'b1;
    #12;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Pre-lock noise: nothing may pulse.
    beat(1'b1, 1'b0, 8'h99);
    beat(1'b1, 1'b0, 8'h9A);
    beat(1'b1, 1'b0, 8'h9B);
    idle(1);
    chk("noise_locked", 32'(bus.locked), 32'h0);

    // Basic frame.
    beat(1'b1, 1'b1, 8'h11, 4'b0001);
    beat(1'b1, 1'b0, 8'h22, 4'b0010);
    beat(1'b1, 1'b0, 8'h33, 4'b0100);
    beat(1'b1, 1'b0, 8'h44, 4'b1000, 1'b0, 1'b1, 32'h44332211);
    idle(1);

    // Stalls inside a frame leave outputs alone.
    beat(1'b1, 1'b1, 8'h55, 4'b0001);
    idle(1);
    beat(1'b1, 1'b0, 8'h66, 4'b0010);
    idle(2);
    chk("stall_frame_hold", bus.out_frame, 32'h44332211);
    beat(1'b1, 1'b0, 8'h77, 4'b0100);
    idle(1);
    beat(1'b1, 1'b0, 8'h88, 4'b1000, 1'b0, 1'b1, 32'h88776655);

    // Back-to-back frames.
    beat(1'b1, 1'b1, 8'hC0, 4'b0001);
    beat(1'b1, 1'b0, 8'hC1, 4'b0010);
    beat(1'b1, 1'b0, 8'hC2, 4'b0100);
    beat(1'b1, 1'b0, 8'hC3, 4'b1000, 1'b0, 1'b1, 32'hC3C2C1C0);
    beat(1'b1, 1'b1, 8'hD0, 4'b0001);
    beat(1'b1, 1'b0, 8'hD1, 4'b0010);
    beat(1'b1, 1'b0, 8'hD2, 4'b0100);
    beat(1'b1, 1'b0, 8'hD3, 4'b1000, 1'b0, 1'b1, 32'hD3D2D1D0);
    idle(1);
    if (ov_cyc.size() >= 2) begin
      chk("ov_spacing", 32'(ov_cyc[ov_cyc.size()-1] - ov_cyc[ov_cyc.size()-2]), 32'd4);
    end else begin
      chk("ov_count", 32'(ov_cyc.size()), 32'd2);
    end

    // Early sync: partial A-frame discarded.
    beat(1'b1, 1'b1, 8'hA0, 4'b0001);
    beat(1'b1, 1'b0, 8'hA1, 4'b0010);
    beat(1'b1, 1'b1, 8'hB0, 4'b0001, 1'b1);
    beat(1'b1, 1'b0, 8'hB1, 4'b0010);
    beat(1'b1, 1'b0, 8'hB2, 4'b0100);
    beat(1'b1, 1'b0, 8'hB3, 4'b1000, 1'b0, 1'b1, 32'hB3B2B1B0);

    // Missing sync: error, lose lock, ignore until next sync.
    beat(1'b1, 1'b0, 8'h55, 4'b0000, 1'b1, 1'b0, 32'h0, 1'b0);
    beat(1'b1, 1'b0, 8'h66);
    beat(1'b1, 1'b0, 8'h77);
    idle(1);
    chk("missing_locked", 32'(bus.locked), 32'h0);
    chk("missing_frame_hold", bus.out_frame, 32'hB3B2B1B0);

    // Reset mid-frame, asserted between edges.
    beat(1'b1, 1'b1, 8'hE0, 4'b0001);
    beat(1'b1, 1'b0, 8'hE1, 4'b0010);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("postrst");
    beat(1'b1, 1'b1, 8'h01, 4'b0001);
    beat(1'b1, 1'b0, 8'h02, 4'b0010);
    beat(1'b1, 1'b0, 8'h03, 4'b0100);
    beat(1'b1, 1'b0, 8'h04, 4'b1000, 1'b0, 1'b1, 32'h04030201);
    idle(3);

    chk("queue_empty", 32'(exq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receive end of the 4:1 TDM link built on the team's 4x1 multiplexer. It accepts one WIDTH-bit slot per valid beat, uses a frame-sync marker to align slot 0, and routes each beat to its channel. Each completed frame is presented as a registered, parallel 4-channel word with a one-cycle strobe. It sits between the serial link front-end and the per-channel consumers.

## Interface
Parameters:
- WIDTH, 8, bits per slot/channel
- NCH, 4, channels per frame; fixed at 4 for this block; SELW = 2 derived

Ports:
- clk  in  1  rising-edge clock, sole clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat present on in_data this cycle
- in_sync  in  1  qualifies the current beat as slot 0; ignored when in_valid=0
- in_data  in  WIDTH  slot payload
- out_frame  out  NCH*WIDTH  completed frame; channel k at bits [k*WIDTH +: WIDTH]
- out_valid  out  1  one-cycle pulse; out_frame updated this cycle
- ch_stb  out  NCH  one-hot pulse; bit k high the cycle after a slot-k beat is accepted
- locked  out  1  high while in LOCKED
- sync_err  out  1  one-cycle pulse on a framing violation

## Operation
- States: HUNT and LOCKED. Internal slot counter slot[1:0] and shadow registers sh[0..2].
- Beats with in_valid=0 are stalls. Nothing changes, and the counter holds.
- HUNT:
  - A beat without in_sync is dropped, with no strobe and no error.
  - A beat with in_sync is accepted as slot 0. The block enters LOCKED and sets slot=1.
- LOCKED, beat with slot=0:
  - in_sync is required. If it is present, the beat is accepted and slot becomes 1.
  - If in_sync is absent: pulse sync_err, drop the beat, go to HUNT.
- LOCKED, beat with slot≠0 and in_sync=1 (early sync):
  - Pulse sync_err and discard the partial frame.
  - Accept the beat as slot 0 and stay LOCKED with slot=1.
- LOCKED, beat with slot≠0 and in_sync=0:
  - Store in sh[slot] and increment slot.
  - At slot=3 the beat completes the frame. out_frame ← {in_data, sh[2], sh[1], sh[0]}, out_valid pulses, slot wraps to 0.
- Every accepted beat pulses ch_stb[slot-of-beat], including a resync beat (ch_stb[0]).
- out_frame holds its last value between frames and is never partially updated.
- A discarded partial frame never reaches out_frame.

## Timing
- All outputs are registered.
- out_valid, ch_stb and sync_err are high for exactly the cycle after the edge that sampled the causing beat.
- Latency from the slot-3 beat to out_valid is 1 cycle.
- Minimum frame period is 4 cycles (back-to-back beats). Sustained throughput is 1 beat/cycle with no bubbles at the frame wrap.
- locked is high from the cycle after the accepting sync beat. It drops the cycle after a missing-sync error.
- Reset (asynchronous, takes effect immediately, mid-frame included):
  - State returns to HUNT.
  - slot, sh, out_frame, out_valid, ch_stb, locked and sync_err all go to 0.
  - The first edge after rst deasserts samples normally.

## Structure
- Package tdm_pkg holds:
  - the state enum (ST_HUNT=0, ST_LOCKED=1)
  - TDM_NCH=4 and TDM_SELW=2
  - a slot-index typedef, shared with the multiplexer-side framer
- Sub-module tdm_slot_counter is the natural split. It takes clk, rst, inc and clr, outputs slot and last (slot==NCH-1), and wraps mod NCH.
- The FSM, shadow registers and output registers live in tdm_demux4.

## Test plan
- Basic frame: in HUNT, drive beats 0x11(sync), 0x22, 0x33, 0x44 back-to-back.
  - out_frame=0x44332211 with out_valid high one cycle, 1 cycle after the 0x44 beat.
  - ch_stb sequence 0001, 0010, 0100, 1000; locked=1.
- Stalls and back-to-back frames:
  - Insert in_valid=0 gaps inside a frame, then send two consecutive frames with sync each.
  - Output values are unchanged by the gaps, and two out_valid pulses arrive exactly 4 beats apart.
- Early sync:
  - Send 0xA0(sync), 0xA1, then 0xB0(sync), 0xB1, 0xB2, 0xB3.
  - sync_err pulses on the 0xB0 beat and locked stays 1.
  - Only out_frame=0xB3B2B1B0 is produced.
- Missing sync:
  - After a full frame, send 0x55 without sync.
  - sync_err pulses and locked falls, with no ch_stb.
  - Subsequent non-sync beats are ignored until the next sync.
- Reset mid-frame:
  - Assert rst asynchronously (between edges) after 2 beats.
  - All outputs go to 0 immediately and locked=0.
  - After release, a fresh frame 0x01..0x04 yields 0x04030201.
- Pre-lock noise: beats without sync in HUNT produce no out_valid, ch_stb or sync_err.
